mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: maximum consecutive grants to one requester while the other is requesting; legal range 1..15.
REQ-002 mem_clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 mem_rst_n  input  1  asynchronous, active-low reset.
REQ-004 rq0_req  input  1  requester 0 access request; level, held until granted.
REQ-005 rq0_we  input  1  requester 0 write (1) / read (0); valid while rq0_req=1.
REQ-006 rq0_addr  input  6  requester 0 word address.
REQ-007 rq0_wdata  input  32  requester 0 write data.
REQ-008 rq0_gnt  output  1  requester 0 access accepted at the rising edge ending this cycle.
REQ-009 rq0_rvalid  output  1  requester 0 read data valid this cycle.
REQ-010 rq0_rdata  output  32  requester 0 read data.
REQ-011 rq1_req, rq1_we, rq1_addr, rq1_wdata, rq1_gnt, rq1_rvalid, rq1_rdata: same directions, widths and meanings for requester 1.
REQ-012 mc_address_mem  output  6  RAM address.
REQ-013 mem_data_in  output  32  RAM write data.
REQ-014 mem_we  output  1  RAM write enable.
REQ-015 mem_data_out  input  32  RAM read data; shows the word at the address registered on the previous edge.

Function
REQ-016 State: FSM {IDLE, OWN0, OWN1}; 4-bit burst counter cnt; 1-bit priority pointer ptr.
REQ-017 Grant G is combinational from state, cnt, ptr and the reqs; at most one of rq0_gnt/rq1_gnt is 1 per cycle.
REQ-018 IDLE: if exactly one req is asserted, G = that requester; if both, G = ptr; if neither, G = none.
REQ-019 OWNk: G = k if rqk_req=1 and not (other req=1 and cnt==MAX_BURST); otherwise G = other if other req=1; otherwise G = none.
REQ-020 Next state: G=none -> IDLE, cnt=0; G equals current owner -> stay, cnt=min(cnt+1, MAX_BURST); any other G -> OWN(G), cnt=1.
REQ-021 ptr <= the non-granted requester on every edge where G is not none; ptr holds otherwise.
REQ-022 RAM mux is combinational: when G=k, mc_address_mem=rqk_addr, mem_data_in=rqk_wdata, mem_we=rqk_we.
REQ-023 G=none: mem_we=0, mc_address_mem=0, mem_data_in=0.
REQ-024 A granted access completes at the edge ending the grant cycle; the requester may change its inputs after that edge.
REQ-025 Read latency 1: a granted read (we=0) by k at edge T sets rqk_rvalid=1 for exactly the cycle after T; rvalid is registered.
REQ-026 rq0_rdata and rq1_rdata both continuously equal mem_data_out; rvalid qualifies them.
REQ-027 Back-to-back reads by either requester are accepted every cycle; rvalid may be 1 on consecutive cycles and may go to requester 1 in the cycle after a requester-0 grant.
REQ-028 A read of an address granted the cycle after a write to it returns the new data; no hazard logic is required.
REQ-029 Lone requester: with the other req=0, the owner is granted every cycle indefinitely; cnt saturates at MAX_BURST.
REQ-030 MAX_BURST=1: strict alternation whenever both reqs are asserted.

Reset
REQ-031 While mem_rst_n=0, asynchronously: state=IDLE, cnt=0, ptr=0, rq0_rvalid=rq1_rvalid=0.
REQ-032 While mem_rst_n=0, both gnt outputs and mem_we are forced to 0 immediately, regardless of req inputs.
REQ-033 A read granted in the cycle that reset asserts produces no rvalid after reset releases.
REQ-034 The first grant after release follows the IDLE rule with ptr=0.

Verification
REQ-035 rq0 writes 0xDEADBEEF to addr 5, then rq0 reads addr 5 -> rq0_gnt=1 in each request cycle, mem_we=1 only in the write cycle, rq0_rvalid=1 one cycle after the read grant with rq0_rdata=0xDEADBEEF, and rq1_rvalid stays 0.
REQ-036 Both reqs asserted continuously from reset, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,0,... and never both gnts high.
REQ-037 rq1 requesting alone for 10 cycles -> rq1_gnt=1 in all 10 cycles and cnt holds at 4.
REQ-038 rq0 writes 0x12345678 to addr 63 in cycle T, rq1 reads addr 63 in T+1 -> rq1_rvalid=1 in T+2 with rq1_rdata=0x12345678.
REQ-039 Reset asserted in the OWN1 state during an rq1 write grant -> mem_we and rq1_gnt fall to 0 with no clock edge; after release with both reqs asserted -> rq0 is granted first.
REQ-040 MAX_BURST=1 with both reqs asserted, all reads -> grants alternate 0,1,0,1 and the rvalids alternate, each one cycle behind its grant.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between two memory requesters, the arbiter and a single-port RAM.
// The slave modport is the arbiter's view; the master modport is the requesters and RAM.
interface mem_arbiter_if;
  logic        rq0_req;
  logic        rq0_we;
  logic [5:0]  rq0_addr;
  logic [31:0] rq0_wdata;
  logic        rq0_gnt;
  logic        rq0_rvalid;
  logic [31:0] rq0_rdata;

  logic        rq1_req;
  logic        rq1_we;
  logic [5:0]  rq1_addr;
  logic [31:0] rq1_wdata;
  logic        rq1_gnt;
  logic        rq1_rvalid;
  logic [31:0] rq1_rdata;

  logic [5:0]  mc_address_mem;
  logic [31:0] mem_data_in;
  logic        mem_we;
  logic [31:0] mem_data_out;

  modport slave (
    input  rq0_req, rq0_we, rq0_addr, rq0_wdata,
    input  rq1_req, rq1_we, rq1_addr, rq1_wdata,
    input  mem_data_out,
    output rq0_gnt, rq0_rvalid, rq0_rdata,
    output rq1_gnt, rq1_rvalid, rq1_rdata,
    output mc_address_mem, mem_data_in, mem_we
  );

  modport master (
    output rq0_req, rq0_we, rq0_addr, rq0_wdata,
    output rq1_req, rq1_we, rq1_addr, rq1_wdata,
    output mem_data_out,
    input  rq0_gnt, rq0_rvalid, rq0_rdata,
    input  rq1_gnt, rq1_rvalid, rq1_rdata,
    input  mc_address_mem, mem_data_in, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port RAM: bounded bursts for the current owner,
// a round-robin pointer for simultaneous requests from idle, and 1-cycle read valid.
module mem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          mem_clk,
  input  logic          mem_rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_t     state;
  logic [3:0] cnt;
  logic       ptr;
  logic       rvalid0_q;
  logic       rvalid1_q;

  logic       g_vld;
  logic       g_id;
  logic       g_we;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    g_vld = 1'b0;
    g_id  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rq0_req && bus.rq1_req) begin
          g_vld = 1'b1;
          g_id  = ptr;
        end else if (bus.rq0_req || bus.rq1_req) begin
          g_vld = 1'b1;
          g_id  = bus.rq1_req;
        end
      end
      OWN0: begin
        if (bus.rq0_req && !(bus.rq1_req && cnt == MAX_CNT)) begin
          g_vld = 1'b1;
          g_id  = 1'b0;
        end else if (bus.rq1_req) begin
          g_vld = 1'b1;
          g_id  = 1'b1;
        end
      end
      OWN1: begin
        if (bus.rq1_req && !(bus.rq0_req && cnt == MAX_CNT)) begin
          g_vld = 1'b1;
          g_id  = 1'b1;
        end else if (bus.rq0_req) begin
          g_vld = 1'b1;
          g_id  = 1'b0;
        end
      end
      default: begin
        g_vld = 1'b0;
        g_id  = 1'b0;
      end
    endcase
    // Reset must kill the grant (and with it mem_we) without waiting for a clock edge.
    if (!mem_rst_n) g_vld = 1'b0;
  end

  assign g_we = g_id ? bus.rq1_we : bus.rq0_we;

  assign bus.rq0_gnt        = g_vld && !g_id;
  assign bus.rq1_gnt        = g_vld &&  g_id;
  assign bus.mem_we         = g_vld && g_we;
  assign bus.mc_address_mem = !g_vld ? 6'd0  : (g_id ? bus.rq1_addr  : bus.rq0_addr);
  assign bus.mem_data_in    = !g_vld ? 32'd0 : (g_id ? bus.rq1_wdata : bus.rq0_wdata);

  assign bus.rq0_rdata  = bus.mem_data_out;
  assign bus.rq1_rdata  = bus.mem_data_out;
  assign bus.rq0_rvalid = rvalid0_q;
  assign bus.rq1_rvalid = rvalid1_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ptr       <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= g_vld && !g_id && !bus.rq0_we;
      rvalid1_q <= g_vld &&  g_id && !bus.rq1_we;

      if (!g_vld) begin
        state <= IDLE;
        cnt   <= 4'd0;
      end else if ((state == OWN0 && !g_id) || (state == OWN1 && g_id)) begin
        cnt <= (cnt < MAX_CNT) ? cnt + 4'd1 : cnt;
      end else begin
        state <= g_id ? OWN1 : OWN0;
        cnt   <= 4'd1;
      end

      // The pointer favours whoever lost (or was not asking) on the last granted cycle.
      if (g_vld) ptr <= !g_id;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed cycles push expected bus/grant and read
// responses into queues; negedge monitors pop and compare against both DUT instances.
module tb_mem_arbiter;

  logic mem_clk = 1'b0;
  logic mem_rst_n;

  always #5 mem_clk = ~mem_clk;

  mem_arbiter_if bus_a ();
  mem_arbiter_if bus_b ();

  mem_arbiter #(.MAX_BURST(4)) dut_a (
    .mem_clk   (mem_clk),
    .mem_rst_n (mem_rst_n),
    .bus       (bus_a.slave)
  );

  mem_arbiter #(.MAX_BURST(1)) dut_b (
    .mem_clk   (mem_clk),
    .mem_rst_n (mem_rst_n),
    .bus       (bus_b.slave)
  );

  // RAM models: address registered on the edge, data shown combinationally from it.
  logic [31:0] ram_a [64];
  logic [31:0] ram_b [64];
  logic [5:0]  raddr_a;
  logic [5:0]  raddr_b;

  always @(posedge mem_clk) begin
    if (bus_a.mem_we) ram_a[bus_a.mc_address_mem] <= bus_a.mem_data_in;
    raddr_a <= bus_a.mc_address_mem;
    if (bus_b.mem_we) ram_b[bus_b.mc_address_mem] <= bus_b.mem_data_in;
    raddr_b <= bus_b.mc_address_mem;
  end

  assign bus_a.mem_data_out = ram_a[raddr_a];
  assign bus_b.mem_data_out = ram_b[raddr_b];

  typedef struct packed {
    logic [1:0]  gnt;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct packed {
    logic        who;
    logic [31:0] data;
  } rd_exp_t;

  bus_exp_t gq_a [$];
  bus_exp_t gq_b [$];
  rd_exp_t  rq_a [$];
  rd_exp_t  rq_b [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge mem_clk) begin
    bus_exp_t e;
    rd_exp_t  r;
    if (mem_rst_n === 1'b1) begin
      check("onehot_a", 64'(bus_a.rq0_gnt & bus_a.rq1_gnt), 64'd0);
      if (gq_a.size() != 0) begin
        e = gq_a.pop_front();
        check("gnt_a",   64'({bus_a.rq1_gnt, bus_a.rq0_gnt}), 64'(e.gnt));
        check("we_a",    64'(bus_a.mem_we),         64'(e.we));
        check("addr_a",  64'(bus_a.mc_address_mem), 64'(e.addr));
        check("wdata_a", 64'(bus_a.mem_data_in),    64'(e.wdata));
      end
      if (bus_a.rq0_rvalid || bus_a.rq1_rvalid) begin
        if (rq_a.size() == 0) begin
          check("rvalid_a_spurious", 64'({bus_a.rq1_rvalid, bus_a.rq0_rvalid}), 64'd0);
        end else begin
          r = rq_a.pop_front();
          check("rvalid_who_a", 64'({bus_a.rq1_rvalid, bus_a.rq0_rvalid}),
                r.who ? 64'd2 : 64'd1);
          check("rdata_a", 64'(r.who ? bus_a.rq1_rdata : bus_a.rq0_rdata), 64'(r.data));
        end
      end

      check("onehot_b", 64'(bus_b.rq0_gnt & bus_b.rq1_gnt), 64'd0);
      if (gq_b.size() != 0) begin
        e = gq_b.pop_front();
        check("gnt_b",   64'({bus_b.rq1_gnt, bus_b.rq0_gnt}), 64'(e.gnt));
        check("we_b",    64'(bus_b.mem_we),         64'(e.we));
        check("addr_b",  64'(bus_b.mc_address_mem), 64'(e.addr));
        check("wdata_b", 64'(bus_b.mem_data_in),    64'(e.wdata));
      end
      if (bus_b.rq0_rvalid || bus_b.rq1_rvalid) begin
        if (rq_b.size() == 0) begin
          check("rvalid_b_spurious", 64'({bus_b.rq1_rvalid, bus_b.rq0_rvalid}), 64'd0);
        end else begin
          r = rq_b.pop_front();
          check("rvalid_who_b", 64'({bus_b.rq1_rvalid, bus_b.rq0_rvalid}),
                r.who ? 64'd2 : 64'd1);
          check("rdata_b", 64'(r.who ? bus_b.rq1_rdata : bus_b.rq0_rdata), 64'(r.data));
        end
      end
    end
  end

  task automatic step();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic drive(input bit sel,
                       input logic r0, input logic w0, input logic [5:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [5:0] a1, input logic [31:0] d1);
    if (sel) begin
      bus_b.rq0_req = r0; bus_b.rq0_we = w0; bus_b.rq0_addr = a0; bus_b.rq0_wdata = d0;
      bus_b.rq1_req = r1; bus_b.rq1_we = w1; bus_b.rq1_addr = a1; bus_b.rq1_wdata = d1;
    end else begin
      bus_a.rq0_req = r0; bus_a.rq0_we = w0; bus_a.rq0_addr = a0; bus_a.rq0_wdata = d0;
      bus_a.rq1_req = r1; bus_a.rq1_we = w1; bus_a.rq1_addr = a1; bus_a.rq1_wdata = d1;
    end
  endtask

  // One bus cycle: drive requests, record the hand-chosen grant g (and read data rd
  // expected one cycle later if g selects a read), then cross the edge.
  task automatic cyc(input bit sel,
                     input logic r0, input logic w0, input logic [5:0] a0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [5:0] a1, input logic [31:0] d1,
                     input logic [1:0] g, input logic [31:0] rd);
    bus_exp_t e;
    rd_exp_t  r;
    drive(sel, r0, w0, a0, d0, r1, w1, a1, d1);
    e = '0;
    e.gnt = g;
    if (g == 2'b01) begin
      e.we = w0; e.addr = a0; e.wdata = d0;
    end else if (g == 2'b10) begin
      e.we = w1; e.addr = a1; e.wdata = d1;
    end
    if (sel) gq_b.push_back(e); else gq_a.push_back(e);
    if (g != 2'b00 && !e.we) begin
      r.who  = g[1];
      r.data = rd;
      if (sel) rq_b.push_back(r); else rq_a.push_back(r);
    end
    step();
  endtask

  task automatic idle(input bit sel);
    cyc(sel, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0, 2'b00, 32'd0);
  endtask

  task automatic reset_pulse();
    mem_rst_n = 1'b0;
    step();
    mem_rst_n = 1'b1;
  endtask

  logic [1:0] burst_pat [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0);
    #1 mem_rst_n = 1'b0;
    #1;
    check("rst_cnt",     64'(dut_a.cnt), 64'd0);
    check("rst_ptr",     64'(dut_a.ptr), 64'd0);
    check("rst_rvalid",  64'({bus_a.rq1_rvalid, bus_a.rq0_rvalid}), 64'd0);
    // Requests (even writes) during reset must not produce a grant or a RAM write.
    drive(1'b0, 1'b1, 1'b1, 6'd1, 32'h1, 1'b1, 1'b1, 6'd2, 32'h2);
    #1;
    check("rst_gnt_forced", 64'({bus_a.rq1_gnt, bus_a.rq0_gnt}), 64'd0);
    check("rst_we_forced",  64'(bus_a.mem_we), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0);
    repeat (2) @(posedge mem_clk);
    #1 mem_rst_n = 1'b1;

    // rq0 write then read of addr 5; rq1 writes addr 6 while rq0's read data returns.
    cyc(1'b0, 1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0, 32'd0, 2'b01, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 6'd5, 32'd0,        1'b0, 1'b0, 6'd0, 32'd0, 2'b01, 32'hDEADBEEF);
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b1, 6'd6, 32'hCAFEF00D, 2'b10, 32'd0);
    idle(1'b0);

    // Both requesters continuously from reset: bursts of four each.
    reset_pulse();
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 6'd5, 32'd0, 1'b1, 1'b0, 6'd6, 32'd0, burst_pat[i],
          (burst_pat[i] == 2'b01) ? 32'hDEADBEEF : 32'hCAFEF00D);
    end
    idle(1'b0);

    // rq1 alone for ten cycles: granted every cycle, counter saturates at 4.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd6, 32'd0, 2'b10, 32'hCAFEF00D);
      if (i == 3) check("cnt_sat_4", 64'(dut_a.cnt), 64'd4);
    end
    check("cnt_sat_10", 64'(dut_a.cnt), 64'd4);
    check("ptr_lone",   64'(dut_a.ptr), 64'd0);
    idle(1'b0);

    // Cross-requester write-then-read of addr 63 on consecutive cycles.
    cyc(1'b0, 1'b1, 1'b1, 6'd63, 32'h12345678, 1'b0, 1'b0, 6'd0, 32'd0, 2'b01, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd63, 32'd0, 2'b10, 32'h12345678);
    idle(1'b0);

    // Reset mid-cycle while rq1 owns the bus with a write grant.
    cyc(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b1, 6'd10, 32'hAAAA0010, 2'b10, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b1, 6'd11, 32'hBBBB0011);
    #1;
    check("own1_gnt_pre",  64'({bus_a.rq1_gnt, bus_a.rq0_gnt}), 64'd2);
    check("own1_we_pre",   64'(bus_a.mem_we), 64'd1);
    mem_rst_n = 1'b0;
    #1;
    check("own1_gnt_rst",  64'({bus_a.rq1_gnt, bus_a.rq0_gnt}), 64'd0);
    check("own1_we_rst",   64'(bus_a.mem_we), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 6'd5, 32'd0, 1'b1, 1'b0, 6'd63, 32'd0);
    step();
    check("rst_state_cnt", 64'(dut_a.cnt), 64'd0);
    mem_rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 6'd5, 32'd0, 1'b1, 1'b0, 6'd63, 32'd0, 2'b01, 32'hDEADBEEF);
    cyc(1'b0, 1'b1, 1'b0, 6'd5, 32'd0, 1'b1, 1'b0, 6'd63, 32'd0, 2'b01, 32'hDEADBEEF);
    idle(1'b0);

    // MAX_BURST=1 instance: seed two words, then strict alternation on reads.
    cyc(1'b1, 1'b1, 1'b1, 6'd3, 32'h00003333, 1'b0, 1'b0, 6'd0, 32'd0, 2'b01, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b1, 6'd4, 32'h44440000, 2'b10, 32'd0);
    idle(1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 6'd3, 32'd0, 1'b1, 1'b0, 6'd4, 32'd0,
          (i % 2 == 0) ? 2'b01 : 2'b10,
          (i % 2 == 0) ? 32'h00003333 : 32'h44440000);
    end
    idle(1'b1);
    idle(1'b1);

    check("gq_a_drained", 64'(gq_a.size()), 64'd0);
    check("rq_a_drained", 64'(rq_a.size()), 64'd0);
    check("gq_b_drained", 64'(gq_b.size()), 64'd0);
    check("rq_b_drained", 64'(rq_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
